hub75_scan_sequencer: RTL and testbench

//  Sequences one HUB75 1/16-scan panel from the dual-buffered RGB565 framebuffer. Per row
//  and per bit-plane it reads a row pair, shifts COLS columns, latches, then unblanks for
//  a binary-weighted (BCM) time. Sits between the framebuffer read ports and the panel pins.

---
 rtl/hub75_scan_sequencer.sv | 167 ++++++++++++++++
 tb/tb_hub75_scan_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hub75_scan_sequencer.sv
// rtl/hub75_scan_sequencer.sv - HUB75 1/16-scan BCM sequencer with frame-boundary buffer swap
// Shift a row pair per bit-plane, latch, then unblank for a binary-weighted time.
module hub75_scan_sequencer #(
   parameter int COLS          = 64,
   parameter int ROW_ADDR_BITS = 4,
   parameter int PLANES        = 5,
   parameter int BASE_TIME     = 4
) (
   input  logic                                   pixel_clk,
   input  logic                                   reset,
   input  logic                                   enable,
   output logic [ROW_ADDR_BITS+$clog2(COLS)-1:0]  fb_rd_addr,
   input  logic [15:0]                            fb_top_data,
   input  logic [15:0]                            fb_bot_data,
   output logic                                   fb_sel,
   input  logic                                   swap_req,
   output logic                                   swap_ack,
   output logic [1:0]                             hub75_red,
   output logic [1:0]                             hub75_green,
   output logic [1:0]                             hub75_blue,
   output logic [ROW_ADDR_BITS-1:0]               hub75_addr,
   output logic                                   hub75_clk,
   output logic                                   hub75_latch,
   output logic                                   hub75_oe
);

   localparam int CB = $clog2(COLS);
   localparam int AW = ROW_ADDR_BITS + CB;
   localparam int KW = $clog2(2*COLS + 2);
   localparam int DW = $clog2(BASE_TIME << (PLANES - 1)) + 1;
   localparam logic [2:0] PLANE_LAST = 3'(PLANES - 1);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_LATCH, S_DISPLAY} state_t;

   state_t                   r_state;
   logic [KW-1:0]            r_k;
   logic [DW-1:0]            r_disp_cnt;
   logic [ROW_ADDR_BITS-1:0] r_row;
   logic [2:0]               r_plane;
   logic [AW-1:0]            r_fb_rd_addr;
   logic                     r_fb_sel;
   logic                     r_swap_ack;
   logic [1:0]               r_red;
   logic [1:0]               r_green;
   logic [1:0]               r_blue;
   logic [ROW_ADDR_BITS-1:0] r_hub75_addr;
   logic                     r_hub75_clk;
   logic                     r_hub75_latch;
   logic                     r_hub75_oe;

   logic [KW-1:0]            w_k_nxt;
   logic [2:0]               w_bit;
   logic [4:0]               w_top_r, w_top_g, w_top_b;
   logic [4:0]               w_bot_r, w_bot_g, w_bot_b;
   logic                     w_plane_last;
   logic                     w_frame_end;
   logic                     w_disp_last;
   logic [ROW_ADDR_BITS-1:0] w_row_nxt;
   logic                     w_unused;

   assign w_k_nxt      = r_k + 1'b1;
   assign w_bit        = 3'(5 - PLANES) + r_plane;
   assign w_top_r      = fb_top_data[15:11];
   assign w_top_g      = fb_top_data[10:6];
   assign w_top_b      = fb_top_data[4:0];
   assign w_bot_r      = fb_bot_data[15:11];
   assign w_bot_g      = fb_bot_data[10:6];
   assign w_bot_b      = fb_bot_data[4:0];
   // Green LSB never reaches the panel: 5-bit depth per channel.
   assign w_unused     = fb_top_data[5] ^ fb_bot_data[5];
   assign w_plane_last = (r_plane == PLANE_LAST);
   assign w_frame_end  = w_plane_last && (&r_row);
   assign w_disp_last  = (r_disp_cnt == DW'((BASE_TIME << r_plane) - 1));
   assign w_row_nxt    = w_plane_last ? r_row + 1'b1 : r_row;

   always_ff @(posedge pixel_clk or negedge reset) begin
      if (!reset) begin
         r_state       <= S_IDLE;
         r_k           <= '0;
         r_disp_cnt    <= '0;
         r_row         <= '0;
         r_plane       <= '0;
         r_fb_rd_addr  <= '0;
         r_fb_sel      <= 1'b0;
         r_swap_ack    <= 1'b0;
         r_red         <= '0;
         r_green       <= '0;
         r_blue        <= '0;
         r_hub75_addr  <= '0;
         r_hub75_clk   <= 1'b0;
         r_hub75_latch <= 1'b0;
         r_hub75_oe    <= 1'b1;
      end else begin
         r_swap_ack <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_hub75_oe    <= 1'b1;
               r_hub75_clk   <= 1'b0;
               r_hub75_latch <= 1'b0;
               if (enable) begin
                  r_state      <= S_SHIFT;
                  r_k          <= '0;
                  r_fb_rd_addr <= {r_row, {CB{1'b0}}};
               end
            end
            S_SHIFT: begin
               // Each column takes two cycles: address, then data; the panel clock rises one cycle after data lands.
               if (r_k[0] && (r_k < KW'(2*COLS))) begin
                  r_red   <= {w_bot_r[w_bit], w_top_r[w_bit]};
                  r_green <= {w_bot_g[w_bit], w_top_g[w_bit]};
                  r_blue  <= {w_bot_b[w_bit], w_top_b[w_bit]};
               end
               if (r_k == KW'(2*COLS + 1)) begin
                  r_state       <= S_LATCH;
                  r_hub75_latch <= 1'b1;
                  r_hub75_addr  <= r_row;
                  r_hub75_clk   <= 1'b0;
               end else begin
                  r_k         <= w_k_nxt;
                  r_hub75_clk <= w_k_nxt[0] && (w_k_nxt >= KW'(3));
                  if (w_k_nxt < KW'(2*COLS))
                     r_fb_rd_addr <= {r_row, w_k_nxt[CB:1]};
               end
            end
            S_LATCH: begin
               r_state       <= S_DISPLAY;
               r_hub75_latch <= 1'b0;
               r_hub75_oe    <= 1'b0;
               r_disp_cnt    <= '0;
            end
            S_DISPLAY: begin
               if (w_disp_last) begin
                  r_hub75_oe <= 1'b1;
                  r_row      <= w_row_nxt;
                  r_plane    <= w_plane_last ? 3'd0 : r_plane + 3'd1;
                  if (w_frame_end && swap_req) begin
                     r_fb_sel   <= ~r_fb_sel;
                     r_swap_ack <= 1'b1;
                  end
                  if (enable) begin
                     r_state      <= S_SHIFT;
                     r_k          <= '0;
                     r_fb_rd_addr <= {w_row_nxt, {CB{1'b0}}};
                  end else begin
                     r_state <= S_IDLE;
                  end
               end else begin
                  r_disp_cnt <= r_disp_cnt + 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign fb_rd_addr  = r_fb_rd_addr;
   assign fb_sel      = r_fb_sel;
   assign swap_ack    = r_swap_ack;
   assign hub75_red   = r_red;
   assign hub75_green = r_green;
   assign hub75_blue  = r_blue;
   assign hub75_addr  = r_hub75_addr;
   assign hub75_clk   = r_hub75_clk;
   assign hub75_latch = r_hub75_latch;
   assign hub75_oe    = r_hub75_oe;

endmodule

// File: tb/tb_hub75_scan_sequencer.sv
// tb/tb_hub75_scan_sequencer.sv - randomized self-checking bench for hub75_scan_sequencer
// A panel-level monitor checks every plane against a framebuffer model and schedule arithmetic.
module tb_hub75_scan_sequencer;

   localparam int COLS   = 64;
   localparam int RAB    = 4;
   localparam int PLANES = 5;
   localparam int BASE   = 4;
   localparam int ROWS   = 1 << RAB;
   localparam int AW     = RAB + $clog2(COLS);

   logic          pixel_clk = 1'b0;
   logic          reset = 1'b0;
   logic          enable = 1'b0;
   logic          swap_req = 1'b0;
   logic [15:0]   fb_top_data = '0;
   logic [15:0]   fb_bot_data = '0;
   logic [AW-1:0] fb_rd_addr;
   logic          fb_sel, swap_ack;
   logic [1:0]    hub75_red, hub75_green, hub75_blue;
   logic [RAB-1:0] hub75_addr;
   logic          hub75_clk, hub75_latch, hub75_oe;

   hub75_scan_sequencer #(.COLS(COLS), .ROW_ADDR_BITS(RAB), .PLANES(PLANES), .BASE_TIME(BASE)) dut (
      .pixel_clk(pixel_clk), .reset(reset), .enable(enable),
      .fb_rd_addr(fb_rd_addr), .fb_top_data(fb_top_data), .fb_bot_data(fb_bot_data),
      .fb_sel(fb_sel), .swap_req(swap_req), .swap_ack(swap_ack),
      .hub75_red(hub75_red), .hub75_green(hub75_green), .hub75_blue(hub75_blue),
      .hub75_addr(hub75_addr), .hub75_clk(hub75_clk), .hub75_latch(hub75_latch), .hub75_oe(hub75_oe)
   );

   always #5 pixel_clk = ~pixel_clk;

   logic [15:0] top_mem [ROWS*COLS];
   logic [15:0] bot_mem [ROWS*COLS];

   // Synchronous-read framebuffer: data for the address seen at an edge appears just after it.
   always @(posedge pixel_clk) begin : fb_model
      logic [AW-1:0] a;
      a = fb_rd_addr;
      #1;
      fb_top_data = top_mem[a];
      fb_bot_data = bot_mem[a];
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int plane_period(input int p);
      return 2*COLS + 3 + (BASE << p);
   endfunction

   function automatic int frame_len();
      int s;
      s = 0;
      for (int p = 0; p < PLANES; p++) s += plane_period(p);
      return ROWS * s;
   endfunction

   function automatic logic [5:0] pix_exp(input int row, input int c, input int p);
      int b;
      logic [15:0] t, u;
      b = 5 - PLANES + p;
      t = top_mem[row*COLS + c] >> b;
      u = bot_mem[row*COLS + c] >> b;
      return {u[11], t[11], u[6], t[6], u[0], t[0]};
   endfunction

   int   cyc = 0, exp_n = 0, oe_low = 0, last_latch = 0, prev_plane = 0;
   int   frame_t = 0, frames_done = 0, ack_cnt = 0;
   bit   have_prev = 0, frame_valid = 0, exp_sel = 0, ev_latch = 0;
   logic p_clk = 1'b0, p_latch = 1'b0, p_oe = 1'b1;
   logic [5:0] p_rgb = '0;
   logic [5:0] rise_q [$];

   // One clock of panel-side observation; exp_n is the running plane count since reset.
   task automatic step();
      logic exp_ack;
      int row, pl;
      @(negedge pixel_clk);
      cyc++;
      exp_ack  = 1'b0;
      ev_latch = 0;
      row = (exp_n / PLANES) % ROWS;
      pl  = exp_n % PLANES;
      if (hub75_clk && !p_clk) rise_q.push_back(p_rgb);
      if (!hub75_oe) oe_low++;
      if (hub75_latch && !p_latch) begin
         ev_latch = 1;
         check("latch_addr", 32'(hub75_addr), 32'(row));
         check("clk_rises", 32'(rise_q.size()), 32'(COLS));
         for (int c = 0; c < rise_q.size() && c < COLS; c++)
            check($sformatf("pixel r%0d c%0d p%0d", row, c, pl), 32'(rise_q[c]), 32'(pix_exp(row, c, pl)));
         if (have_prev) check("plane_period", 32'(cyc - last_latch), 32'(plane_period(prev_plane)));
         if (pl == 0 && row == 0) begin
            if (frame_valid) begin
               check("frame_len", 32'(cyc - frame_t), 32'(frame_len()));
               frames_done++;
            end
            frame_t     = cyc;
            frame_valid = 1;
         end
         last_latch = cyc;
         prev_plane = pl;
         have_prev  = 1;
         rise_q.delete();
      end
      if (hub75_oe && !p_oe) begin
         check("display_len", 32'(oe_low), 32'(BASE << pl));
         oe_low  = 0;
         exp_ack = (pl == PLANES-1) && (row == ROWS-1) && swap_req;
         if (exp_ack) exp_sel = !exp_sel;
         exp_n++;
      end
      check("oe_exclusive", 32'((!hub75_oe) && (hub75_latch || hub75_clk)), 32'(0));
      check("swap_state", 32'({swap_ack, fb_sel}), 32'({exp_ack, exp_sel}));
      if (swap_ack) begin
         ack_cnt++;
         swap_req = 1'b0;
      end
      p_clk   = hub75_clk;
      p_latch = hub75_latch;
      p_oe    = hub75_oe;
      p_rgb   = {hub75_red, hub75_green, hub75_blue};
   endtask

   task automatic wait_latch(input string tag);
      int k;
      k = 0;
      do begin
         step();
         k++;
      end while (!ev_latch && k < 2000);
      check({tag, "_timeout"}, 32'(ev_latch), 32'(1));
   endtask

   task automatic wait_planes(input int n, input int budget, input string tag);
      int k;
      k = 0;
      while (exp_n < n && k < budget) begin
         step();
         k++;
      end
      check(tag, 32'(exp_n >= n), 32'(1));
   endtask

   initial begin
      int n_stop, k;
      for (int i = 0; i < ROWS*COLS; i++) begin
         top_mem[i] = 16'hF800;
         bot_mem[i] = 16'h07E0;
      end
      reset = 1'b0;
      repeat (3) @(negedge pixel_clk);
      check("rst_oe", 32'(hub75_oe), 32'(1));
      check("rst_pins", 32'({hub75_latch, hub75_clk, hub75_addr}), 32'(0));
      check("rst_rgb", 32'({hub75_red, hub75_green, hub75_blue}), 32'(0));
      check("rst_fb", 32'({fb_sel, swap_ack, fb_rd_addr}), 32'(0));
      reset = 1'b1;
      repeat (3) step();
      check("idle_blank", 32'({hub75_oe, hub75_latch, hub75_clk}), 32'(3'b100));

      // Solid red top / green bottom across the first row.
      enable = 1'b1;
      wait_latch("first_latch");
      check("red_pattern", 32'(hub75_red), 32'(2'b01));
      check("green_pattern", 32'(hub75_green), 32'(2'b10));
      check("blue_pattern", 32'(hub75_blue), 32'(2'b00));
      wait_planes(5, 5000, "row0_planes");

      // Drop enable in the middle of a shift; the plane must still finish.
      k = 0;
      while (rise_q.size() == 0 && k < 500) begin
         step();
         k++;
      end
      check("in_shift", 32'(rise_q.size() > 0), 32'(1));
      n_stop = exp_n;
      enable = 1'b0;
      wait_planes(n_stop + 1, 1000, "plane_finish");
      repeat (20) begin
         step();
         check("idle_hold", 32'({hub75_oe, hub75_latch, hub75_clk}), 32'(3'b100));
      end
      check("idle_no_advance", 32'(exp_n), 32'(n_stop + 1));

      // Blue MSB only: visible in the top half on the last plane alone.
      for (int i = 0; i < ROWS*COLS; i++) begin
         top_mem[i] = 16'h0010;
         bot_mem[i] = 16'h0000;
      end
      have_prev   = 0;
      frame_valid = 0;
      enable      = 1'b1;
      for (int i = 0; i < PLANES; i++) begin
         wait_latch("blue_latch");
         check("blue_plane", 32'(hub75_blue), 32'(((exp_n % PLANES) == PLANES-1) ? 2'b01 : 2'b00));
      end

      // Random image, free run, one swap request mid-frame.
      n_stop = exp_n;
      enable = 1'b0;
      wait_planes(n_stop + 1, 1000, "stop_for_fill");
      for (int i = 0; i < ROWS*COLS; i++) begin
         top_mem[i] = 16'($urandom);
         bot_mem[i] = 16'($urandom);
      end
      have_prev   = 0;
      frame_valid = 0;
      frames_done = 0;
      enable      = 1'b1;
      repeat (1000 + $urandom_range(0, 3000)) step();
      swap_req = 1'b1;
      k = 0;
      while (frames_done < 1 && k < 30000) begin
         step();
         k++;
      end
      check("frame_seen", 32'(frames_done), 32'(1));
      check("ack_count", 32'(ack_cnt), 32'(1));
      check("sel_after_swap", 32'(fb_sel), 32'(1));
      k = 0;
      while (frames_done < 2 && k < 15000) begin
         step();
         k++;
      end
      check("frame_seen2", 32'(frames_done), 32'(2));
      check("ack_count2", 32'(ack_cnt), 32'(1));

      // Asynchronous reset in the middle of DISPLAY.
      k = 0;
      while (hub75_oe && k < 500) begin
         step();
         k++;
      end
      check("in_display", 32'(hub75_oe), 32'(0));
      #2 reset = 1'b0;
      #1;
      check("arst_oe", 32'(hub75_oe), 32'(1));
      check("arst_pins", 32'({hub75_latch, hub75_clk, hub75_addr}), 32'(0));
      check("arst_swap", 32'({fb_sel, swap_ack}), 32'(0));
      enable = 1'b0;
      @(negedge pixel_clk);
      reset = 1'b1;
      @(negedge pixel_clk);
      check("post_reset_idle", 32'({hub75_oe, fb_sel}), 32'(2'b10));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
